// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and defaults for the framebuffer line-prefetch
// controller / memory arbiter (vga_fb_fetch_arb).
//   fetch_state_e : fetch FSM encoding (IDLE, FETCH, DRAIN)
//   PIX_W_DEF     : default pixel width
//   ADDR_W_DEF    : default pixel-memory address width
package vga_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int PIX_W_DEF  = 24;
  localparam int ADDR_W_DEF = 20;

endpackage

// File: rtl/vga_fb_fetch_arb_if.sv
// vga_fb_fetch_arb_if: host write handshake plus single-port pixel memory bus.
//   wr_valid/wr_ready/wr_addr/wr_data : host write request channel
//   mem_addr/mem_we/mem_wdata         : memory command (arbiter drives)
//   mem_rdata                         : memory read data (fixed latency)
// modport slave  : the arbiter side
// modport master : host + memory side
interface vga_fb_fetch_arb_if
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_line_buffer.sv
// vga_line_buffer: ping-pong line buffer, 2 banks x WIDTH pixels.
//   clk, rst        : clock, async active-high reset (read register only)
//   we/wbank/waddr/wdata : synchronous write port
//   rd_en/rbank/raddr    : read request; rdata is registered, 0 when !rd_en
// The bank select is the address MSB. Storage itself is not reset.
module vga_line_buffer #(
  parameter int WIDTH = 1024,
  parameter int PIX_W = 24,
  parameter int XW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             wbank,
  input  logic [XW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rd_en,
  input  logic             rbank,
  input  logic [XW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  localparam int DEPTH = 2 ** (XW + 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) rdata_d = mem[{rbank, raddr}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/vga_fb_fetch_arb.sv
// vga_fb_fetch_arb: framebuffer line prefetch + memory port arbiter.
//   clk, rst          : clock, async active-high reset
//   fetch_req/fetch_y : request a burst read of line fetch_y into the back bank
//   swap              : toggle front/back banks
//   rd_en/rd_x        : display read; color_out is the registered front pixel
//   bus (slave)       : host write handshake and memory port
//   fetch_busy/fetch_done/err_overrun/err_underrun : status
// Build option: VGA_FB_HOST_SLOT_EN reserves every HOST_PERIOD-th FETCH cycle
// for a host write; without it the host is blocked for the whole FETCH state.
module vga_fb_fetch_arb
  import vga_fb_pkg::*;
#(
  parameter int WIDTH       = 1024,
  parameter int HEIGHT      = 768,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int RD_LAT      = 1,
  parameter int HOST_PERIOD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [9:0]         fetch_y,
  input  logic               swap,
  input  logic               rd_en,
  input  logic [9:0]         rd_x,
  output logic [PIX_W-1:0]   color_out,
  vga_fb_fetch_arb_if.slave  bus,
  output logic               fetch_busy,
  output logic               fetch_done,
  output logic               err_overrun,
  output logic               err_underrun
);
  localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (RD_LAT > HOST_PERIOD) ? RD_LAT : HOST_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [XW-1:0]     fetch_x_q, fetch_x_d;
  logic              tgt_bank_q, tgt_bank_d;
  logic              disp_bank_q, disp_bank_d;
  logic              fetch_done_q, fetch_done_d;
  // One counter serves as the host-slot phase in FETCH and the wait in DRAIN.
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RD_LAT-1:0]          vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][XW-1:0]  xpipe_q, xpipe_d;
  logic issue, slot, grant, rd_ok;

  always_comb begin
    state_d      = state_q;
    line_base_d  = line_base_q;
    fetch_x_d    = fetch_x_q;
    tgt_bank_d   = tgt_bank_q;
    cnt_d        = '0;
    fetch_done_d = 1'b0;
    issue        = 1'b0;
    disp_bank_d  = disp_bank_q ^ swap;
`ifdef VGA_FB_HOST_SLOT_EN
    slot = (state_q == ST_FETCH) && (cnt_q == CW'(HOST_PERIOD - 1));
`else
    slot = 1'b0;
`endif
    // wr_ready depends on state only; a granted write always wins the port.
    bus.wr_ready  = (state_q != ST_FETCH) || slot;
    grant         = bus.wr_ready && bus.wr_valid;
    bus.mem_we    = grant;
    bus.mem_addr  = grant ? bus.wr_addr : '0;
    bus.mem_wdata = grant ? bus.wr_data : '0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req && (int'(fetch_y) < HEIGHT)) begin
          state_d     = ST_FETCH;
          line_base_d = ADDR_W'(int'(fetch_y) * WIDTH);
          fetch_x_d   = '0;
          // A same-cycle swap is applied first, so target the new back bank.
          tgt_bank_d  = ~disp_bank_d;
        end
      end
      ST_FETCH: begin
`ifdef VGA_FB_HOST_SLOT_EN
        cnt_d = slot ? '0 : cnt_q + 1'b1;
`endif
        if (!grant) begin
          issue        = 1'b1;
          bus.mem_addr = line_base_q + ADDR_W'(fetch_x_q);
          fetch_x_d    = fetch_x_q + 1'b1;
          if (fetch_x_q == XW'(WIDTH - 1)) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d      = ST_IDLE;
          fetch_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: tag each issue with its x and retire it RD_LAT cycles later.
  always_comb begin
    vld_pipe_d    = '0;
    xpipe_d       = '0;
    vld_pipe_d[0] = issue;
    xpipe_d[0]    = fetch_x_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      xpipe_d[i]    = xpipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_base_q  <= '0;
      fetch_x_q    <= '0;
      tgt_bank_q   <= 1'b0;
      disp_bank_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      cnt_q        <= '0;
      vld_pipe_q   <= '0;
      xpipe_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_base_q  <= line_base_d;
      fetch_x_q    <= fetch_x_d;
      tgt_bank_q   <= tgt_bank_d;
      disp_bank_q  <= disp_bank_d;
      fetch_done_q <= fetch_done_d;
      cnt_q        <= cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      xpipe_q      <= xpipe_d;
    end
  end

  assign rd_ok = rd_en && (int'(rd_x) < WIDTH);

  vga_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W), .XW(XW)) u_lbuf (
    .clk   (clk),
    .rst   (rst),
    .we    (vld_pipe_q[RD_LAT-1]),
    .wbank (tgt_bank_q),
    .waddr (xpipe_q[RD_LAT-1]),
    .wdata (bus.mem_rdata),
    .rd_en (rd_ok),
    .rbank (disp_bank_q),
    .raddr (rd_x[XW-1:0]),
    .rdata (color_out)
  );

  assign fetch_busy   = (state_q != ST_IDLE);
  assign fetch_done   = fetch_done_q;
  assign err_overrun  = fetch_req && fetch_busy;
  assign err_underrun = swap && fetch_busy;
endmodule
